// File: rtl/mem_access_ctrl.sv
// Data-memory access controller between the ALU and the data memory.
// Runs one req/ack access at a time, returns read data, and aborts stalled accesses.
module mem_access_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MemIO,
  input  logic [ADDR_W-1:0] ALUAddr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              ValidMemData,
  output logic              WrDone,
  output logic              Busy,
  output logic              ErrTimeout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0]  IO_RD    = 2'b01;
  localparam logic [1:0]  IO_WR    = 2'b10;
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DONE = 3'd2,
    WR_REQ  = 3'd3,
    WR_DONE = 3'd4
  } state_t;

  state_t state, state_d;

  logic [15:0]       wdog_q, wdog_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] rd_data_d;
  logic              valid_d, wr_done_d, busy_d, err_d, req_d, we_d;
  logic              in_req, wd_expired;

  // Handshake: mem_req rises the cycle after a request is sampled and stays high,
  // with mem_addr/mem_wdata/mem_we frozen, until the edge that sees mem_ack=1 or the
  // watchdog limit; mem_ack is only honoured while mem_req is high.
  assign in_req     = (state == RD_REQ) || (state == WR_REQ);
  assign wd_expired = in_req && !mem_ack && (wdog_q == WD_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wdog_q       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      RdData       <= '0;
      ValidMemData <= 1'b0;
      WrDone       <= 1'b0;
      Busy         <= 1'b0;
      ErrTimeout   <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
    end else begin
      state        <= state_d;
      wdog_q       <= wdog_d;
      mem_addr     <= addr_d;
      mem_wdata    <= wdata_d;
      RdData       <= rd_data_d;
      ValidMemData <= valid_d;
      WrDone       <= wr_done_d;
      Busy         <= busy_d;
      ErrTimeout   <= err_d;
      mem_req      <= req_d;
      mem_we       <= we_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (MemIO == IO_RD)      state_d = RD_REQ;
        else if (MemIO == IO_WR) state_d = WR_REQ;
      end
      RD_REQ: begin
        if (mem_ack)         state_d = RD_DONE;
        else if (wd_expired) state_d = IDLE;
      end
      // Leaving RD_DONE doubles as an IDLE sample so a following write is not delayed.
      RD_DONE: begin
        if (MemIO == IO_RD) begin
          if (ALUAddr != mem_addr) state_d = RD_REQ;
        end else if (MemIO == IO_WR) begin
          state_d = WR_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        if (mem_ack)         state_d = WR_DONE;
        else if (wd_expired) state_d = IDLE;
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    rd_data_d = RdData;
    wdog_d    = '0;

    if ((state_d == RD_REQ) && (state != RD_REQ)) begin
      addr_d = ALUAddr;
    end
    if ((state_d == WR_REQ) && (state != WR_REQ)) begin
      addr_d  = ALUAddr;
      wdata_d = WrData;
    end
    if ((state == RD_REQ) && mem_ack) begin
      rd_data_d = mem_rdata;
    end
    // Counter restarts from zero on every entry into a request state.
    if (in_req && !mem_ack && !wd_expired) begin
      wdog_d = wdog_q + 16'd1;
    end

    valid_d   = (state_d == RD_DONE);
    wr_done_d = (state_d == WR_DONE);
    busy_d    = (state_d == RD_REQ) || (state_d == WR_REQ) || (state_d == WR_DONE);
    req_d     = (state_d == RD_REQ) || (state_d == WR_REQ);
    we_d      = (state_d == WR_REQ);
    err_d     = wd_expired;
  end

  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_req && $past(mem_req)) |-> ((mem_addr == $past(mem_addr)) &&
      (mem_wdata == $past(mem_wdata)) && (mem_we == $past(mem_we))));

  a_done_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ValidMemData && WrDone));

  a_timeout_drops_req: assert property (@(posedge clk) disable iff (rst)
    ErrTimeout |-> (!mem_req && !ValidMemData && !WrDone));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 4-cycle watchdog; the bench plays the memory.
module tb_mem_access_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mem_io = 2'b00;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          valid_mem_data, wr_done, busy, err_timeout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .MemIO(mem_io), .ALUAddr(alu_addr), .WrData(wr_data),
    .RdData(rd_data), .ValidMemData(valid_mem_data), .WrDone(wr_done), .Busy(busy),
    .ErrTimeout(err_timeout), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] io, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_io   = io;
    alu_addr = a;
    wr_data  = d;
  endtask

  task automatic ack_with(input logic [DW-1:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    exp_q.push_back(d);
  endtask

  task automatic ack_clear();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic check_read(input string tag);
    logic [DW-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_eq({tag, "_valid"}, valid_mem_data, 1'b1);
    check_eq({tag, "_rdata"}, rd_data, e);
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    step();
    step();
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", valid_mem_data, 0);
    check_eq("rst_wrdone", wr_done, 0);
    check_eq("rst_err", err_timeout, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_rdata", rd_data, 0);
    rst = 1'b0;
    step();

    // Read 0x10, ack three cycles after mem_req rises
    req(2'b01, 32'h10, 32'h0);
    step();
    check_eq("rd_req", mem_req, 1);
    check_eq("rd_we", mem_we, 0);
    check_eq("rd_addr", mem_addr, 32'h10);
    check_eq("rd_busy", busy, 1);
    step();
    step();
    check_eq("rd_req_held", mem_req, 1);
    check_eq("rd_no_valid_yet", valid_mem_data, 0);
    ack_with(32'hDEADBEEF);
    step();
    ack_clear();
    check_read("rd1");
    check_eq("rd1_req_drop", mem_req, 0);
    check_eq("rd1_busy_drop", busy, 0);
    step();
    check_read_hold: begin
      check_eq("rd1_hold_valid", valid_mem_data, 1);
      check_eq("rd1_hold_rdata", rd_data, 32'hDEADBEEF);
    end
    req(2'b00, 32'h10, 32'h0);
    step();
    check_eq("rd1_release_valid", valid_mem_data, 0);
    check_eq("rd1_release_rdata", rd_data, 32'hDEADBEEF);

    // Write 0x1234 to 0x20; request inputs wiggle while in flight
    req(2'b10, 32'h20, 32'h1234);
    step();
    check_eq("wr_req", mem_req, 1);
    check_eq("wr_we", mem_we, 1);
    check_eq("wr_addr", mem_addr, 32'h20);
    check_eq("wr_wdata", mem_wdata, 32'h1234);
    check_eq("wr_busy", busy, 1);
    req(2'b01, 32'h99, 32'hFFFF);
    step();
    check_eq("wr_addr_stable", mem_addr, 32'h20);
    check_eq("wr_wdata_stable", mem_wdata, 32'h1234);
    check_eq("wr_we_stable", mem_we, 1);
    req(2'b00, 32'h0, 32'h0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_eq("wr_done_pulse", wr_done, 1);
    check_eq("wr_done_busy", busy, 1);
    check_eq("wr_done_req_drop", mem_req, 0);
    step();
    check_eq("wr_done_end", wr_done, 0);
    check_eq("wr_idle_busy", busy, 0);

    // Watchdog: read 0x30 never acked, abort after edge 4
    req(2'b01, 32'h30, 32'h0);
    step();
    req(2'b00, 32'h0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq($sformatf("to_wait%0d_err", i), err_timeout, 0);
      check_eq($sformatf("to_wait%0d_req", i), mem_req, 1);
    end
    step();
    check_eq("to_err", err_timeout, 1);
    check_eq("to_req_drop", mem_req, 0);
    check_eq("to_valid", valid_mem_data, 0);
    check_eq("to_busy", busy, 0);
    step();
    check_eq("to_err_pulse_end", err_timeout, 0);
    check_eq("to_valid_after", valid_mem_data, 0);

    // Minimum-latency read after a timeout
    req(2'b01, 32'h40, 32'h0);
    step();
    ack_with(32'hCAFE0001);
    step();
    ack_clear();
    check_read("rd_min");
    req(2'b00, 32'h0, 32'h0);
    step();

    // Back-to-back reads with an address change in RD_DONE
    req(2'b01, 32'h10, 32'h0);
    step();
    ack_with(32'h11111111);
    step();
    ack_clear();
    check_read("rd_a");
    alu_addr = 32'h14;
    step();
    check_eq("rd_b_valid_drop", valid_mem_data, 0);
    check_eq("rd_b_req", mem_req, 1);
    check_eq("rd_b_addr", mem_addr, 32'h14);
    ack_with(32'h22222222);
    step();
    ack_clear();
    check_read("rd_b");

    // Write issued straight from RD_DONE
    req(2'b10, 32'h64, 32'hABCD);
    step();
    check_eq("rdwr_valid_drop", valid_mem_data, 0);
    check_eq("rdwr_we", mem_we, 1);
    check_eq("rdwr_addr", mem_addr, 32'h64);
    check_eq("rdwr_wdata", mem_wdata, 32'hABCD);
    req(2'b00, 32'h0, 32'h0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_eq("rdwr_done", wr_done, 1);
    step();

    // Ack lands on the watchdog-limit edge: read completes, no error
    req(2'b01, 32'h50, 32'h0);
    step();
    step();
    step();
    step();
    check_eq("lim_req_held", mem_req, 1);
    ack_with(32'h5A5A5A5A);
    step();
    ack_clear();
    check_eq("lim_err", err_timeout, 0);
    check_read("lim");
    req(2'b00, 32'h0, 32'h0);
    step();
    check_eq("lim_err_after", err_timeout, 0);

    // GPR-only request and stray ack in IDLE are ignored
    req(2'b11, 32'h80, 32'h0);
    mem_ack = 1'b1;
    step();
    check_eq("gpr_req", mem_req, 0);
    check_eq("gpr_busy", busy, 0);
    check_eq("stray_ack_valid", valid_mem_data, 0);
    check_eq("stray_ack_wrdone", wr_done, 0);
    mem_ack = 1'b0;
    step();
    check_eq("gpr_req2", mem_req, 0);

    // Reset in the middle of RD_REQ drops mem_req without waiting for a clock
    req(2'b01, 32'h70, 32'h0);
    step();
    check_eq("mid_rst_req_before", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_req", mem_req, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_addr", mem_addr, 0);
    req(2'b00, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_eq("post_rst_req", mem_req, 0);
    check_eq("post_rst_valid", valid_mem_data, 0);
    check_eq("post_rst_busy", busy, 0);

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
